// File: rtl/pred_stack.sv
`default_nettype none
// ============================================================================
// Module      : pred_stack
// Description : Per-warp predicate/divergence mask stack. Push (IF), pop
//               (ENDIF) and complement (ELSE) strobes update a nesting stack
//               whose top entry drives the lane active mask. It also returns
//               the all-true/all-false flags the control unit uses to branch
//               over IF/ELSE bodies.
// Revision    : 1.0 - initial release
// ============================================================================
module pred_stack #(
  parameter int NUM_LANES = 8,
  parameter int DEPTH     = 8,
  parameter int DW        = 4   // 2**DW must exceed DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pstack_push,
  input  logic                 pstack_pop,
  input  logic                 pstack_complement,
  input  logic [NUM_LANES-1:0] pred_in,
  output logic [NUM_LANES-1:0] active_mask,
  output logic                 all_mask_false,
  output logic                 all_mask_true,
  output logic [DW-1:0]        depth,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 op_err
);

  localparam logic [NUM_LANES-1:0] c_all_ones  = '1;
  localparam logic [DW-1:0]        c_depth_max = DW'(DEPTH);
  localparam logic [DW-1:0]        c_depth_one = DW'(1);

  // Entry 0 is the implicit all-ones base; only entries 1..DEPTH are stored.
  logic [NUM_LANES-1:0] r_mask [1:DEPTH];
  logic [DW-1:0]        r_depth;
  logic [NUM_LANES-1:0] r_active;   // copy of mask[depth], kept off the array read path
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_op_err;

  logic [NUM_LANES-1:0] w_parent;
  logic [1:0]           w_nstrb;
  logic                 w_conflict;
  logic                 w_at_base;
  logic                 w_at_top;
  logic                 w_wr_en;
  logic [DW-1:0]        w_wr_idx;
  logic [NUM_LANES-1:0] w_wr_data;
  logic [DW-1:0]        w_depth_nxt;
  logic [NUM_LANES-1:0] w_active_nxt;
  logic                 w_ovf_set;
  logic                 w_unf_set;

  assign w_nstrb    = 2'(pstack_push) + 2'(pstack_pop) + 2'(pstack_complement);
  assign w_conflict = (w_nstrb > 2'd1);
  assign w_at_base  = (r_depth == '0);
  assign w_at_top   = (r_depth == c_depth_max);

  // Parent entry select: mask[depth-1], with depth 0/1 falling back to the all-ones base.
  always_comb begin
    w_parent = c_all_ones;
    for (int i = 1; i < DEPTH; i++) begin
      if (r_depth == DW'(i + 1)) w_parent = r_mask[i];
    end
  end

  // Next-state decode for a single legal strobe; conflicting strobes only raise op_err.
  always_comb begin
    w_depth_nxt  = r_depth;
    w_active_nxt = r_active;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_depth;
    w_wr_data    = r_active & pred_in;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    if (!w_conflict) begin
      if (pstack_push) begin
        if (w_at_top) begin
          w_ovf_set = 1'b1;
        end else begin
          w_wr_en      = 1'b1;
          w_wr_idx     = r_depth + c_depth_one;
          w_wr_data    = r_active & pred_in;
          w_depth_nxt  = r_depth + c_depth_one;
          w_active_nxt = r_active & pred_in;
        end
      end else if (pstack_pop) begin
        if (w_at_base) begin
          w_unf_set = 1'b1;
        end else begin
          w_depth_nxt  = r_depth - c_depth_one;
          w_active_nxt = w_parent;
        end
      end else if (pstack_complement) begin
        if (w_at_base) begin
          w_unf_set = 1'b1;
        end else begin
          w_wr_en      = 1'b1;
          w_wr_idx     = r_depth;
          w_wr_data    = w_parent & ~r_active;
          w_active_nxt = w_parent & ~r_active;
        end
      end
    end
  end

  // Stack entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 1; i <= DEPTH; i++) begin
      if (w_wr_en && (w_wr_idx == DW'(i))) r_mask[i] <= w_wr_data;
    end
  end

  // Depth, active mask and sticky error flags, cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth     <= '0;
      r_active    <= c_all_ones;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_op_err    <= 1'b0;
    end else begin
      r_depth     <= w_depth_nxt;
      r_active    <= w_active_nxt;
      r_overflow  <= r_overflow  | w_ovf_set;
      r_underflow <= r_underflow | w_unf_set;
      r_op_err    <= r_op_err    | w_conflict;
    end
  end

  assign active_mask    = r_active;
  assign depth          = r_depth;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;
  assign op_err         = r_op_err;
  assign all_mask_false = ((r_active & pred_in) == '0);
  assign all_mask_true  = !w_at_base && ((w_parent & ~r_active) == '0);

endmodule
`default_nettype wire

// File: tb/tb_pred_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_pred_stack
// Description : Self-checking bench for pred_stack: directed IF/ELSE/ENDIF,
//               nesting, flag, boundary, conflict and async-reset scenarios,
//               then random strobes against a queue-based stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pred_stack;

  localparam int NL = 8;
  localparam int DP = 8;
  localparam int W  = 4;

  logic          clk;
  logic          reset;
  logic          pstack_push;
  logic          pstack_pop;
  logic          pstack_complement;
  logic [NL-1:0] pred_in;
  logic [NL-1:0] active_mask;
  logic          all_mask_false;
  logic          all_mask_true;
  logic [W-1:0]  depth;
  logic          overflow;
  logic          underflow;
  logic          op_err;

  int n_tests = 0;
  int n_fail  = 0;

  pred_stack #(.NUM_LANES(NL), .DEPTH(DP), .DW(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .pstack_push       (pstack_push),
    .pstack_pop        (pstack_pop),
    .pstack_complement (pstack_complement),
    .pred_in           (pred_in),
    .active_mask       (active_mask),
    .all_mask_false    (all_mask_false),
    .all_mask_true     (all_mask_true),
    .depth             (depth),
    .overflow          (overflow),
    .underflow         (underflow),
    .op_err            (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set strobes for the coming edge.
  task automatic drive(input logic pu, input logic po, input logic co, input logic [NL-1:0] p);
    pstack_push       = pu;
    pstack_pop        = po;
    pstack_complement = co;
    pred_in           = p;
  endtask

  // Advance one edge, sample 1 time unit after it, then drop the strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    pstack_push       = 1'b0;
    pstack_pop        = 1'b0;
    pstack_complement = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    n_tests++; if (active_mask !== 8'hFF) begin n_fail++; $display("FAIL reset_mask got %h exp ff", active_mask); end
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got %0d exp 0", depth); end
    n_tests++; if ({overflow, underflow, op_err} !== 3'b000) begin n_fail++; $display("FAIL reset_errs got %b exp 000", {overflow, underflow, op_err}); end
    n_tests++; if (all_mask_true !== 1'b0) begin n_fail++; $display("FAIL reset_amt got %b exp 0", all_mask_true); end
  endtask

  task automatic test_if_else();
    drive(1'b1, 1'b0, 1'b0, 8'h0F); tick();
    n_tests++; if (active_mask !== 8'h0F || depth !== 4'd1) begin n_fail++; $display("FAIL ie_push got %h/%0d exp 0f/1", active_mask, depth); end
    drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
    n_tests++; if (active_mask !== 8'hF0) begin n_fail++; $display("FAIL ie_else got %h exp f0", active_mask); end
    drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
    n_tests++; if (active_mask !== 8'h0F) begin n_fail++; $display("FAIL ie_else2 got %h exp 0f", active_mask); end
    drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
    n_tests++; if (active_mask !== 8'hFF || depth !== 4'd0) begin n_fail++; $display("FAIL ie_pop got %h/%0d exp ff/0", active_mask, depth); end
  endtask

  task automatic test_nested();
    drive(1'b1, 1'b0, 1'b0, 8'h3C); tick();
    n_tests++; if (active_mask !== 8'h3C) begin n_fail++; $display("FAIL nest_push1 got %h exp 3c", active_mask); end
    drive(1'b1, 1'b0, 1'b0, 8'h0F); tick();
    n_tests++; if (active_mask !== 8'h0C || depth !== 4'd2) begin n_fail++; $display("FAIL nest_push2 got %h/%0d exp 0c/2", active_mask, depth); end
    drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
    n_tests++; if (active_mask !== 8'h30) begin n_fail++; $display("FAIL nest_else got %h exp 30", active_mask); end
    drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
    n_tests++; if (active_mask !== 8'h3C) begin n_fail++; $display("FAIL nest_pop1 got %h exp 3c", active_mask); end
    drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
    n_tests++; if (active_mask !== 8'hFF || depth !== 4'd0) begin n_fail++; $display("FAIL nest_pop2 got %h/%0d exp ff/0", active_mask, depth); end
  endtask

  task automatic test_flags();
    drive(1'b0, 1'b0, 1'b0, 8'h00); #1;
    n_tests++; if (all_mask_false !== 1'b1) begin n_fail++; $display("FAIL flag_amf0 got %b exp 1", all_mask_false); end
    drive(1'b1, 1'b0, 1'b0, 8'hFF); #1;
    n_tests++; if (all_mask_false !== 1'b0) begin n_fail++; $display("FAIL flag_amf1 got %b exp 0", all_mask_false); end
    tick();
    n_tests++; if (all_mask_true !== 1'b1) begin n_fail++; $display("FAIL flag_amt1 got %b exp 1", all_mask_true); end
    drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
    n_tests++; if (active_mask !== 8'h00 || all_mask_true !== 1'b0) begin n_fail++; $display("FAIL flag_amt0 got %h/%b exp 00/0", active_mask, all_mask_true); end
    drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL flag_pop got %0d exp 0", depth); end
  endtask

  task automatic test_boundaries();
    repeat (8) begin drive(1'b1, 1'b0, 1'b0, 8'hFF); tick(); end
    n_tests++; if (depth !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL bnd_full got %0d/%b exp 8/0", depth, overflow); end
    drive(1'b1, 1'b0, 1'b0, 8'hFF); tick();
    n_tests++; if (depth !== 4'd8 || overflow !== 1'b1) begin n_fail++; $display("FAIL bnd_ovf got %0d/%b exp 8/1", depth, overflow); end
    repeat (8) begin drive(1'b0, 1'b1, 1'b0, 8'h00); tick(); end
    n_tests++; if (depth !== 4'd0 || underflow !== 1'b0) begin n_fail++; $display("FAIL bnd_empty got %0d/%b exp 0/0", depth, underflow); end
    drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
    n_tests++; if (depth !== 4'd0 || underflow !== 1'b1 || active_mask !== 8'hFF) begin n_fail++; $display("FAIL bnd_unf got %0d/%b/%h exp 0/1/ff", depth, underflow, active_mask); end
  endtask

  task automatic test_conflict_reset();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h0F); tick();
    drive(1'b1, 1'b1, 1'b0, 8'h03); tick();
    n_tests++; if (op_err !== 1'b1 || depth !== 4'd1 || active_mask !== 8'h0F) begin n_fail++; $display("FAIL conflict got %b/%0d/%h exp 1/1/0f", op_err, depth, active_mask); end
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL conflict_flags got %b%b exp 00", overflow, underflow); end
    repeat (2) begin drive(1'b1, 1'b0, 1'b0, 8'hFF); tick(); end
    n_tests++; if (depth !== 4'd3) begin n_fail++; $display("FAIL pre_reset_depth got %0d exp 3", depth); end
    #3;
    reset = 1'b0;
    #1;
    n_tests++; if (depth !== 4'd0 || active_mask !== 8'hFF || op_err !== 1'b0) begin n_fail++; $display("FAIL async_reset got %0d/%h/%b exp 0/ff/0", depth, active_mask, op_err); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Random strobes checked against a queue holding the whole stack, base entry included.
  task automatic test_random();
    logic [NL-1:0] q[$];
    logic [NL-1:0] t, par, p;
    bit            m_ovf, m_unf, m_oerr;
    bit            e_amf, e_amt;
    logic          pu, po, co;
    int            r;
    do_reset();
    q = {8'hFF};
    m_ovf = 0; m_unf = 0; m_oerr = 0;
    for (int c = 0; c < 400; c++) begin
      r  = int'($urandom_range(0, 15));
      pu = (r <= 5);
      po = (r >= 6 && r <= 9);
      co = (r >= 10 && r <= 12);
      if (r == 15) begin pu = 1'b1; po = $urandom_range(0, 1) == 1; co = !po; end
      case ($urandom_range(0, 3))
        0:       p = 8'hFF;
        1:       p = 8'h00;
        default: p = NL'($urandom);
      endcase
      drive(pu, po, co, p);
      #1;
      t     = q[$];
      par   = (q.size() > 1) ? q[q.size() - 2] : 8'hFF;
      e_amf = ((t & p) == 0);
      e_amt = (q.size() > 1) && ((par & ~t) == 0);
      n_tests++; if (all_mask_false !== e_amf) begin n_fail++; $display("FAIL rnd_amf c=%0d got %b exp %b", c, all_mask_false, e_amf); end
      n_tests++; if (all_mask_true !== e_amt) begin n_fail++; $display("FAIL rnd_amt c=%0d got %b exp %b", c, all_mask_true, e_amt); end
      if ((int'(pu) + int'(po) + int'(co)) > 1) m_oerr = 1;
      else if (pu) begin if (q.size() - 1 < DP) q.push_back(t & p); else m_ovf = 1; end
      else if (po) begin if (q.size() > 1) void'(q.pop_back()); else m_unf = 1; end
      else if (co) begin if (q.size() > 1) q[q.size() - 1] = par & ~t; else m_unf = 1; end
      tick();
      n_tests++; if (active_mask !== q[$]) begin n_fail++; $display("FAIL rnd_mask c=%0d got %h exp %h", c, active_mask, q[$]); end
      n_tests++; if (depth !== W'(q.size() - 1)) begin n_fail++; $display("FAIL rnd_depth c=%0d got %0d exp %0d", c, depth, q.size() - 1); end
      n_tests++; if ({overflow, underflow, op_err} !== {m_ovf, m_unf, m_oerr}) begin n_fail++; $display("FAIL rnd_errs c=%0d got %b exp %b", c, {overflow, underflow, op_err}, {m_ovf, m_unf, m_oerr}); end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    test_reset();
    test_if_else();
    test_nested();
    test_flags();
    test_boundaries();
    test_conflict_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pred_stack.md
Name: pred_stack

Overview:
- Per-warp predicate/divergence mask stack for the SIMT scheduler.
- Responder end of the control unit's pstack_push / pstack_pop / pstack_complement strobes. Returns all_mask_true / all_mask_false so the control unit can branch over IF/ELSE bodies.
- Drives active_mask, which gates per-lane register writes and memory requests in the SM core.

Parameters:
NUM_LANES, 8, lanes per warp (active-mask width)
DEPTH, 8, nesting entries above the base entry (max IF nesting)
DW, 4, depth counter width; must satisfy 2^DW > DEPTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
pstack_push  input  1  IF_P: push (top & pred_in)
pstack_pop  input  1  ENDIF: pop top entry
pstack_complement  input  1  ELSE_P: top <= parent & ~top
pred_in  input  NUM_LANES  current per-lane predicate register (from SETP)
active_mask  output  NUM_LANES  mask of the top entry (registered)
all_mask_false  output  1  no active lane has predicate set
all_mask_true  output  1  top entry equals its parent
depth  output  DW  current nesting level (0 = base)
overflow  output  1  sticky: push attempted at depth==DEPTH
underflow  output  1  sticky: pop/complement attempted at depth==0
op_err  output  1  sticky: more than one strobe asserted in the same cycle

Behaviour:
- Storage: mask[0..DEPTH]. mask[0] is constant all-ones and is never written. top = mask[depth]; parent = mask[depth-1].
- Reset (reset=0, async): depth=0, active_mask=all ones, overflow=underflow=op_err=0. Entries 1..DEPTH are don't-care.
- Reset mid-nesting discards all entries and returns to the reset state immediately.
- All updates occur on the rising clk edge with single-cycle latency. active_mask and depth reflect the new entry in the cycle after the strobe.
- Push:
  - if depth<DEPTH: mask[depth+1] <= top & pred_in; depth <= depth+1.
  - else set overflow; no state change.
- Pop:
  - if depth>0: depth <= depth-1 (entry contents left stale).
  - else set underflow; no state change.
- Complement:
  - if depth>0: mask[depth] <= parent & ~top.
  - else set underflow; no change.
  - A second complement restores the original entry (parent & t is t).
- Strobe conflicts: more than one strobe high in a cycle sets op_err. No stack change, no overflow/underflow update.
- Idle cycles (no strobe): all state held.
- Flags (combinational from registered state and pred_in, valid in the same cycle as the strobe, so the control unit can sample them in its IF/ELSE states):
  - all_mask_false = ((top & pred_in) == 0); evaluated before the push takes effect.
  - all_mask_true = (depth>0) && ((parent & ~top) == 0); 0 at depth 0.
- Sticky error flags clear only on reset.
- active_mask is driven from a register updated alongside mask/depth, not from the array read path.

Test Plan:
- Reset: release reset, idle 3 cycles -> active_mask=8'hFF, depth=0, all error flags 0, all_mask_true=0.
- IF/ELSE/ENDIF:
  - pred_in=8'h0F, push -> next cycle active_mask=8'h0F, depth=1.
  - complement -> active_mask=8'hF0.
  - complement -> 8'h0F.
  - pop -> 8'hFF, depth=0.
- Nested divergence:
  - push pred_in=8'h3C -> 8'h3C.
  - push pred_in=8'h0F -> 8'h0C, depth=2.
  - complement -> 8'h30.
  - pop twice -> 8'hFF.
- Flags:
  - depth 0, pred_in=8'h00 -> all_mask_false=1 same cycle.
  - push pred_in=8'hFF -> all_mask_true=1 at depth 1.
  - complement -> mask 8'h00, all_mask_true=0.
- Boundaries:
  - 8 pushes of 8'hFF -> depth=8, overflow=0.
  - 9th push -> overflow=1, depth stays 8.
  - 8 pops then an extra pop -> underflow=1, depth=0, mask 8'hFF.
- Conflict and reset:
  - push+pop same cycle -> op_err=1, depth unchanged.
  - assert reset asynchronously between clock edges at depth 3 -> depth=0, active_mask=8'hFF immediately, op_err cleared.
